// File: rtl/rrat_ckpt.sv
// Retirement RAT: committed arch->phys map, updated by in-order retire lanes,
// frees displaced tags and streams the table out on mispredict recovery.
module rrat_free_lane #(
    parameter int PREG_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              act,
    input  logic [PREG_W-1:0] t_old,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg
);
    always_ff @(posedge clock) begin
        if (!reset) begin
            free_valid <= 1'b0;
            free_preg  <= '0;
        end else begin
            free_valid <= act;
            free_preg  <= act ? t_old : '0;
        end
    end
endmodule

module rrat_ckpt #(
    parameter int AREG_NUM = 32,
    parameter int PREG_NUM = 64,
    parameter int RETIRE_W = 2,
    parameter int COPY_W   = 8,
    localparam int AREG_W  = $clog2(AREG_NUM),
    localparam int PREG_W  = $clog2(PREG_NUM)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [RETIRE_W-1:0]                 retire_valid,
    input  logic [RETIRE_W-1:0]                 retire_wr,
    input  logic [RETIRE_W-1:0][AREG_W-1:0]     retire_areg,
    input  logic [RETIRE_W-1:0][PREG_W-1:0]     retire_preg,
    output logic [RETIRE_W-1:0]                 free_valid,
    output logic [RETIRE_W-1:0][PREG_W-1:0]     free_preg,
    input  logic                                recover_req,
    output logic                                recover_busy,
    output logic                                copy_valid,
    output logic [AREG_W-1:0]                   copy_base,
    output logic [COPY_W-1:0][PREG_W-1:0]       copy_preg,
    output logic                                copy_done,
    output logic [AREG_NUM-1:0][PREG_W-1:0]     rrat_table
);
    localparam int K  = AREG_NUM / COPY_W;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [AREG_W-1:0] CW = AREG_W'(COPY_W);

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t                               state, state_nxt;
    logic [KW-1:0]                        beat, beat_nxt;
    logic [AREG_NUM-1:0][PREG_W-1:0]      table_q, work;
    logic [RETIRE_W-1:0]                  act;
    logic [RETIRE_W-1:0][PREG_W-1:0]      t_old;
    logic [K-1:0][COPY_W*PREG_W-1:0]      chunk;

    // Lanes walk the working copy in order, so a later lane naturally sees
    // (and frees) the tag an earlier lane just wrote.
    always_comb begin
        work  = table_q;
        act   = '0;
        t_old = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            act[i] = retire_valid[i] & retire_wr[i] & (state == IDLE);
            if (act[i]) begin
                t_old[i]              = work[retire_areg[i]];
                work[retire_areg[i]]  = retire_preg[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < AREG_NUM; i++)
                table_q[i] <= PREG_W'(i);
        end else begin
            table_q <= work;
        end
    end

    for (genvar g = 0; g < RETIRE_W; g++) begin : g_lane
        rrat_free_lane #(.PREG_W(PREG_W)) u_lane (
            .clock      (clock),
            .reset      (reset),
            .act        (act[g]),
            .t_old      (t_old[g]),
            .free_valid (free_valid[g]),
            .free_preg  (free_preg[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            IDLE: if (recover_req) begin
                state_nxt = COPY;
                beat_nxt  = '0;
            end
            COPY: begin
                if (beat == KW'(K - 1)) state_nxt = DONE;
                else                    beat_nxt  = beat + KW'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign chunk        = table_q;
    assign rrat_table   = table_q;
    assign recover_busy = (state != IDLE);
    assign copy_valid   = (state == COPY);
    assign copy_done    = (state == DONE);
    assign copy_base    = copy_valid ? AREG_W'(beat) * CW : '0;
    assign copy_preg    = copy_valid ? chunk[beat] : '0;
endmodule

// File: tb/tb_rrat_ckpt.sv
// Directed bench for rrat_ckpt at default parameters plus a random sweep on a
// wide configuration against a sequential reference table.
module tb_rrat_ckpt;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0]       rv1 = '0, rw1 = '0;
    logic [1:0][4:0]  ra1 = '0;
    logic [1:0][5:0]  rp1 = '0;
    logic [1:0]       fv1;
    logic [1:0][5:0]  fp1;
    logic             req1 = 1'b0, busy1, cv1, cd1;
    logic [4:0]       cb1;
    logic [7:0][5:0]  cp1;
    logic [31:0][5:0] rt1;
    logic [31:0][5:0] exp1;

    logic [3:0]        rv2 = '0, rw2 = '0;
    logic [3:0][5:0]   ra2 = '0;
    logic [3:0][6:0]   rp2 = '0;
    logic [3:0]        fv2, efv;
    logic [3:0][6:0]   fp2, efp;
    logic              req2 = 1'b0, busy2, cv2, cd2;
    logic [5:0]        cb2;
    logic [15:0][6:0]  cp2;
    logic [63:0][6:0]  rt2, m2;

    rrat_ckpt dut1 (
        .clock(clk), .reset(reset),
        .retire_valid(rv1), .retire_wr(rw1), .retire_areg(ra1), .retire_preg(rp1),
        .free_valid(fv1), .free_preg(fp1),
        .recover_req(req1), .recover_busy(busy1),
        .copy_valid(cv1), .copy_base(cb1), .copy_preg(cp1), .copy_done(cd1),
        .rrat_table(rt1)
    );

    rrat_ckpt #(.AREG_NUM(64), .PREG_NUM(128), .RETIRE_W(4), .COPY_W(16)) dut2 (
        .clock(clk), .reset(reset),
        .retire_valid(rv2), .retire_wr(rw2), .retire_areg(ra2), .retire_preg(rp2),
        .free_valid(fv2), .free_preg(fp2),
        .recover_req(req2), .recover_busy(busy2),
        .copy_valid(cv2), .copy_base(cb2), .copy_preg(cp2), .copy_done(cd2),
        .rrat_table(rt2)
    );

    // The ROB must never retire while a copy-out is running.
    always @(posedge clk) begin
        if (reset && busy1 && (|rv1)) $error("protocol: dut1 retire while busy");
        if (reset && busy2 && (|rv2)) $error("protocol: dut2 retire while busy");
    end

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) exp1[i] = 6'(i);
        total++; if (rt1 !== exp1) begin bad++; $display("FAIL reset_table got=%h want=%h", rt1, exp1); end
        total++; if (fv1 !== 2'b00) begin bad++; $display("FAIL reset_free_valid got=%b want=00", fv1); end
        total++; if (fp1 !== '0) begin bad++; $display("FAIL reset_free_preg got=%h want=0", fp1); end
        total++; if ({busy1, cv1, cd1} !== 3'b000) begin bad++; $display("FAIL reset_flags busy/cv/cd got=%b want=000", {busy1, cv1, cd1}); end
        total++; if (cb1 !== '0 || cp1 !== '0) begin bad++; $display("FAIL reset_copy base=%0d preg=%h want 0", cb1, cp1); end
    endtask

    task automatic test_dual;
        rv1 = 2'b11; rw1 = 2'b11; ra1[0] = 5'd3; rp1[0] = 6'd40; ra1[1] = 5'd7; rp1[1] = 6'd41;
        @(negedge clk);
        rv1 = '0; rw1 = '0;
        exp1[3] = 6'd40; exp1[7] = 6'd41;
        total++; if (rt1 !== exp1) begin bad++; $display("FAIL dual_table got=%h want=%h", rt1, exp1); end
        total++; if (fv1 !== 2'b11) begin bad++; $display("FAIL dual_free_valid got=%b want=11", fv1); end
        total++; if (fp1[0] !== 6'd3 || fp1[1] !== 6'd7) begin bad++; $display("FAIL dual_free_preg got=%0d,%0d want=3,7", fp1[0], fp1[1]); end
        @(negedge clk);
        total++; if (fv1 !== 2'b00) begin bad++; $display("FAIL dual_free_one_cycle got=%b want=00", fv1); end
    endtask

    task automatic test_collision;
        rv1 = 2'b11; rw1 = 2'b11; ra1[0] = 5'd5; rp1[0] = 6'd50; ra1[1] = 5'd5; rp1[1] = 6'd51;
        @(negedge clk);
        rv1 = '0; rw1 = '0;
        exp1[5] = 6'd51;
        total++; if (rt1[5] !== 6'd51) begin bad++; $display("FAIL coll_table got=%0d want=51", rt1[5]); end
        total++; if (fv1 !== 2'b11 || fp1[0] !== 6'd5 || fp1[1] !== 6'd50) begin
            bad++; $display("FAIL coll_free got v=%b %0d,%0d want v=11 5,50", fv1, fp1[0], fp1[1]); end
    endtask

    task automatic test_partial;
        // lane0 valid but no destination; lane1 writes
        rv1 = 2'b11; rw1 = 2'b10; ra1[0] = 5'd12; rp1[0] = 6'd33; ra1[1] = 5'd10; rp1[1] = 6'd42;
        @(negedge clk);
        rv1 = '0; rw1 = '0;
        exp1[10] = 6'd42;
        total++; if (rt1 !== exp1) begin bad++; $display("FAIL partial_table got=%h want=%h", rt1, exp1); end
        total++; if (fv1 !== 2'b10 || fp1[0] !== 6'd0 || fp1[1] !== 6'd10) begin
            bad++; $display("FAIL partial_free got v=%b %0d,%0d want v=10 0,10", fv1, fp1[0], fp1[1]); end
    endtask

    task automatic test_recover;
        int busycnt = 0;
        rv1 = 2'b01; rw1 = 2'b01; ra1[0] = 5'd9; rp1[0] = 6'd60; req1 = 1'b1;
        exp1[9] = 6'd60;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy1) busycnt++;
            if (k == 1) begin
                rv1 = '0; rw1 = '0; req1 = 1'b0;
                total++; if (fv1 !== 2'b01 || fp1[0] !== 6'd9) begin bad++; $display("FAIL rec_free got v=%b %0d want v=01 9", fv1, fp1[0]); end
            end
            if (k <= 4) begin
                total++; if (cv1 !== 1'b1 || cb1 !== 5'((k - 1) * 8)) begin
                    bad++; $display("FAIL rec_beat%0d got cv=%b base=%0d want cv=1 base=%0d", k, cv1, cb1, (k - 1) * 8); end
                for (int j = 0; j < 8; j++) begin
                    total++; if (cp1[j] !== exp1[(k - 1) * 8 + j]) begin
                        bad++; $display("FAIL rec_slot b%0d s%0d got=%0d want=%0d", k, j, cp1[j], exp1[(k - 1) * 8 + j]); end
                end
                total++; if (cd1 !== 1'b0) begin bad++; $display("FAIL rec_early_done beat%0d got=1 want=0", k); end
            end
            if (k == 2) begin
                total++; if (cp1[1] !== 6'd60) begin bad++; $display("FAIL rec_beat2_slot1 got=%0d want=60", cp1[1]); end
                req1 = 1'b1;
            end
            if (k == 3) req1 = 1'b0;
            if (k == 5) begin
                total++; if (cd1 !== 1'b1 || cv1 !== 1'b0 || cb1 !== '0 || cp1 !== '0) begin
                    bad++; $display("FAIL rec_done got cd=%b cv=%b base=%0d want cd=1 cv=0 base=0", cd1, cv1, cb1); end
            end
            if (k == 6) begin
                total++; if (cd1 !== 1'b0 || busy1 !== 1'b0 || cv1 !== 1'b0) begin
                    bad++; $display("FAIL rec_idle got cd=%b busy=%b cv=%b want 000", cd1, busy1, cv1); end
            end
        end
        total++; if (busycnt != 5) begin bad++; $display("FAIL rec_busy_len got=%0d want=5", busycnt); end
    endtask

    task automatic test_reset_mid;
        logic saw_done = 1'b0;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        total++; if (cv1 !== 1'b1 || cb1 !== 5'd0) begin bad++; $display("FAIL mid_beat1 got cv=%b base=%0d want 1,0", cv1, cb1); end
        @(negedge clk);
        total++; if (cb1 !== 5'd8) begin bad++; $display("FAIL mid_beat2 got base=%0d want=8", cb1); end
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) exp1[i] = 6'(i);
        total++; if (cv1 !== 1'b0 || busy1 !== 1'b0 || cd1 !== 1'b0) begin
            bad++; $display("FAIL mid_abort got cv=%b busy=%b cd=%b want 000", cv1, busy1, cd1); end
        total++; if (rt1 !== exp1) begin bad++; $display("FAIL mid_table got=%h want=%h", rt1, exp1); end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (cd1 || cv1) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=1 want=0"); end
    endtask

    task automatic test_back_to_back;
        rv1 = 2'b11; rw1 = 2'b11; ra1[0] = 5'd1; rp1[0] = 6'd20; ra1[1] = 5'd2; rp1[1] = 6'd21;
        @(negedge clk);
        total++; if (fv1 !== 2'b11 || fp1[0] !== 6'd1 || fp1[1] !== 6'd2) begin
            bad++; $display("FAIL b2b_a got v=%b %0d,%0d want 11 1,2", fv1, fp1[0], fp1[1]); end
        ra1[0] = 5'd1; rp1[0] = 6'd22; ra1[1] = 5'd2; rp1[1] = 6'd23;
        @(negedge clk);
        total++; if (fv1 !== 2'b11 || fp1[0] !== 6'd20 || fp1[1] !== 6'd21) begin
            bad++; $display("FAIL b2b_b got v=%b %0d,%0d want 11 20,21", fv1, fp1[0], fp1[1]); end
        ra1[0] = 5'd1; rp1[0] = 6'd24; ra1[1] = 5'd3; rp1[1] = 6'd25;
        @(negedge clk);
        rv1 = '0; rw1 = '0;
        total++; if (fv1 !== 2'b11 || fp1[0] !== 6'd22 || fp1[1] !== 6'd3) begin
            bad++; $display("FAIL b2b_c got v=%b %0d,%0d want 11 22,3", fv1, fp1[0], fp1[1]); end
        exp1[1] = 6'd24; exp1[2] = 6'd23; exp1[3] = 6'd25;
        total++; if (rt1 !== exp1) begin bad++; $display("FAIL b2b_table got=%h want=%h", rt1, exp1); end
        @(negedge clk);
        total++; if (fv1 !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b want=00", fv1); end
    endtask

    task automatic test_sweep;
        int nbeat = 0;
        int ndone = 0;
        for (int i = 0; i < 64; i++) m2[i] = 7'(i);
        efv = '0; efp = '0;
        for (int c = 0; c <= 200; c++) begin
            @(negedge clk);
            total++; if (rt2 !== m2) begin bad++; $display("FAIL sweep_table c%0d got=%h want=%h", c, rt2, m2); end
            total++; if (fv2 !== efv || fp2 !== efp) begin
                bad++; $display("FAIL sweep_free c%0d got v=%b p=%h want v=%b p=%h", c, fv2, fp2, efv, efp); end
            if (c == 200) begin
                rv2 = '0; rw2 = '0;
            end else begin
                rv2 = 4'($urandom); rw2 = 4'($urandom);
                for (int i = 0; i < 4; i++) begin
                    ra2[i] = $urandom_range(0, 1) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
                    rp2[i] = 7'($urandom_range(0, 127));
                end
            end
            for (int i = 0; i < 4; i++) begin
                efv[i] = rv2[i] & rw2[i];
                efp[i] = '0;
                if (efv[i]) begin
                    efp[i] = m2[ra2[i]];
                    m2[ra2[i]] = rp2[i];
                end
            end
        end
        req2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req2 = 1'b0;
            if (cd2) ndone++;
            if (cv2) begin
                total++; if (cb2 !== 6'(nbeat * 16)) begin bad++; $display("FAIL sweep_base got=%0d want=%0d", cb2, nbeat * 16); end
                for (int j = 0; j < 16; j++) begin
                    total++; if (cp2[j] !== m2[nbeat * 16 + j]) begin
                        bad++; $display("FAIL sweep_slot b%0d s%0d got=%0d want=%0d", nbeat, j, cp2[j], m2[nbeat * 16 + j]); end
                end
                nbeat++;
            end
        end
        total++; if (nbeat != 4 || ndone != 1) begin bad++; $display("FAIL sweep_beats got=%0d/%0d want=4/1", nbeat, ndone); end
    endtask

    initial begin
        test_reset;
        test_dual;
        test_collision;
        test_partial;
        test_recover;
        test_reset_mid;
        test_back_to_back;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
